jtframe_pdm2pcm: RTL and testbench
==================================

# jtframe_pdm2pcm

1-bit sigma-delta (PDM) to PCM decimator, the receive-side counterpart of the 1-bit hifi DAC used for MiST-family sound output. It takes a 1-bit stream sampled on the same clock enable that drives the DAC, runs it through a 3rd-order CIC decimator, and emits 16-bit PCM words with a single-cycle valid strobe. It is used for DAC loopback checks and for external PDM sources such as microphones or cassette/line-in pins, in the `clk_dac` domain.

## Interface
Parameters:
- `DLOG2`, 6: log2 of the decimation ratio R. Legal range 6..10. Internal width W = 3·DLOG2+1.
- `SIGNED_SND`, 1'b0: output format. 1 gives two's complement PCM; 0 gives offset binary (MSB inverted), matching the DAC input convention.

Ports:
- `clk_dac`  in  1: clock.
- `rst`  in  1: reset; asynchronous, active-high; clock `clk_dac`.
- `cen`  in  1: input sample enable, one `clk_dac` cycle wide.
- `pdm_in`  in  1: PDM bit. It may be asynchronous to `clk_dac`.
- `pcm`  out  16: decimated sample.
- `pcm_valid`  out  1: one-cycle strobe that marks a new `pcm` value.
- `sat`  out  1: high with `pcm_valid` when the current sample was clamped.

## Operation
- **Synchronizer:** `pdm_in` passes through a 2-flop synchronizer clocked every `clk_dac` cycle, not gated by `cen`. Bit 1 counts as +1 and bit 0 counts as 0.
- **Integrators:**
  - Three cascaded, registered integrators of W bits, updated only on `cen`: i1 += x, i2 += i1, i3 += i2.
  - Modulo-2^W wrap-around is intended and must not be saturated.
- **Decimation counter:**
  - A DLOG2-bit counter increments on `cen` and wraps from R−1 to 0.
  - A `cen` cycle with count = R−1 is the decimation tick.
- **Combs:**
  - After each tick, i3 is captured and passed through three cascaded combs, y = x − x_prev, each holding one W-bit delay register.
  - The combs run as a 3-stage pipeline, one `clk_dac` cycle per stage, and need no `cen`.
  - Comb arithmetic is modulo 2^W.
- **Scaling:**
  - d = y3 − 2^(3·DLOG2−1), as a signed W-bit value with range ±2^(3·DLOG2−1).
  - s = d >>> (3·DLOG2−16), an arithmetic shift.
  - If s > 32767, then pcm = 32767 and `sat` = 1. If s < −32768, then pcm = −32768 and `sat` = 1.
  - If SIGNED_SND = 0, `pcm` = s ^ 16'h8000.
- **Filter settling:** comb delay registers start at 0. The first 3 `pcm_valid` samples after reset are transients; samples are exact from the 4th onward.
- **Reset values:**
  - All integrators, combs, the counter and the synchronizer clear to 0.
  - `pcm_valid` = 0 and `sat` = 0.
  - `pcm` = 16'h0000 when SIGNED_SND = 1, and 16'h8000 when SIGNED_SND = 0 (midscale).

## Timing
- **Synchronizer latency:** 2 `clk_dac` cycles from a `pdm_in` change to the synchronized bit.
- **Tick to output:** for a tick at cycle T:
  - T+1: i3 captured into comb stage 1.
  - T+2: comb 2.
  - T+3: comb 3.
  - T+4: `pcm` and `sat` registered, and `pcm_valid` = 1 for exactly that cycle.
- **Output hold:** `pcm` holds its value until the next `pcm_valid`.
- **Output rate:** one `pcm_valid` every R `cen` pulses. The minimum spacing is R ≥ 64 cycles, so the comb pipeline never overlaps itself.
- **`cen` stuck high:** legal. The block decimates at `clk_dac`/R.
- **`cen` low:** integrators and the counter freeze. The comb pipeline still completes any tick already in flight.
- **`rst` mid-pipeline:** the in-flight sample is discarded, no `pcm_valid` is emitted, and the settling rule restarts.
- **Simultaneous tick and in-flight comb stage:** cannot occur for legal R. The verifier asserts that stage occupancy never exceeds one sample.

## Test plan
- **All ones:** DLOG2 = 6, SIGNED_SND = 1, `pdm_in` = 1, `cen` every 4 cycles → from the 4th `pcm_valid`, `pcm` = 32767 and `sat` = 1. `pcm_valid` period = 256 cycles.
- **All zeros:** same setup with `pdm_in` = 0 → `pcm` = −32768 (16'h8000) and `sat` = 0.
- **Alternating bits:** `pdm_in` alternating 1,0 on each `cen`, SIGNED_SND = 0 → settled `pcm` = 16'h8000 and `sat` = 0.
- **Latency:** one decimation tick at cycle T → `pcm_valid` high only at T+4, and low at T+3 and T+5.
- **DAC loopback:** a DAC instance is driven with constant 16-bit PCM 16'h4000 on the same `cen`, and its output feeds this block with DLOG2 = 8 → settled `pcm` within ±2 LSB of 16'h4000.
- **Reset mid-operation:**
  - Assert `rst` 2 cycles after a tick → `pcm_valid` stays 0 and `pcm` returns to its reset value immediately.
  - After release, the next `pcm_valid` comes R `cen` pulses plus 4 cycles later.

Source files
------------

// File: rtl/jtframe_pdm2pcm.sv
// jtframe_pdm2pcm: 1-bit PDM to 16-bit PCM decimator.
// The input is synchronized, then runs through a 3rd-order CIC (integrators on cen,
// combs as a cen-free pipeline), and finally goes through an offset, scale and clamp stage.
module jtframe_pdm2pcm #(
  parameter int   DLOG2      = 6,
  parameter logic SIGNED_SND = 1'b0
) (
  input  logic        clk_dac,
  input  logic        rst,
  input  logic        cen,
  input  logic        pdm_in,
  output logic [15:0] pcm,
  output logic        pcm_valid,
  output logic        sat
);

  localparam int W  = 3*DLOG2 + 1;
  localparam int SH = 3*DLOG2 - 16;

  // Midpoint of the CIC output range, 2^(3*DLOG2-1)
  localparam logic [W-1:0]        OFFSET   = {2'b01, {(3*DLOG2-1){1'b0}}};
  localparam logic [DLOG2-1:0]    CNT_LAST = {DLOG2{1'b1}};
  localparam logic [DLOG2-1:0]    CNT_ONE  = {{(DLOG2-1){1'b0}}, 1'b1};
  localparam logic signed [W-1:0] PMAX     = {{(W-16){1'b0}}, 16'h7FFF};
  localparam logic signed [W-1:0] PMIN     = {{(W-16){1'b1}}, 16'h8000};
  localparam logic [15:0]         PCM_RST  = SIGNED_SND ? 16'h0000 : 16'h8000;
  localparam logic [15:0]         PCM_FLIP = SIGNED_SND ? 16'h0000 : 16'h8000;

  logic [1:0]        sync_q, sync_d;
  logic [W-1:0]      i1_q, i1_d, i2_q, i2_d, i3_q, i3_d;
  logic [DLOG2-1:0]  cnt_q, cnt_d;
  logic [W-1:0]      c1_q, c1_d, c2_q, c2_d, c3_q, c3_d;
  logic [W-1:0]      z1_q, z1_d, z2_q, z2_d, z3_q, z3_d;
  logic [2:0]        stg_q, stg_d;
  logic [15:0]       pcm_q, pcm_d;
  logic              valid_q, valid_d;
  logic              sat_q, sat_d;

  logic [W-1:0]        x_s;
  logic                tick_s;
  logic signed [W-1:0] d_s;
  logic signed [W-1:0] s_s;
  logic [15:0]         clamp_s;
  logic                clamp_sat_s;

  // Next-state logic for synchronizer, CIC integrators/combs and the output stage
  always_comb begin
    sync_d = {sync_q[0], pdm_in};
    x_s    = {{(W-1){1'b0}}, sync_q[1]};
    tick_s = cen & (cnt_q == CNT_LAST);

    // Integrators and the decimation counter advance only on input samples
    if (cen) begin
      i1_d  = i1_q + x_s;
      i2_d  = i2_q + i1_q;
      i3_d  = i3_q + i2_q;
      cnt_d = cnt_q + CNT_ONE;
    end else begin
      i1_d  = i1_q;
      i2_d  = i2_q;
      i3_d  = i3_q;
      cnt_d = cnt_q;
    end

    // Comb stage 1 captures the integrator chain on the decimation tick
    if (tick_s) begin
      c1_d = i3_q - z1_q;
      z1_d = i3_q;
    end else begin
      c1_d = c1_q;
      z1_d = z1_q;
    end

    if (stg_q[0]) begin
      c2_d = c1_q - z2_q;
      z2_d = c1_q;
    end else begin
      c2_d = c2_q;
      z2_d = z2_q;
    end

    if (stg_q[1]) begin
      c3_d = c2_q - z3_q;
      z3_d = c2_q;
    end else begin
      c3_d = c3_q;
      z3_d = z3_q;
    end

    stg_d = {stg_q[1:0], tick_s};

    // Re-center, scale down to 16 bits and clamp
    d_s = c3_q - OFFSET;
    s_s = d_s >>> SH;
    if (s_s > PMAX) begin
      clamp_s     = 16'h7FFF;
      clamp_sat_s = 1'b1;
    end else if (s_s < PMIN) begin
      clamp_s     = 16'h8000;
      clamp_sat_s = 1'b1;
    end else begin
      clamp_s     = s_s[15:0];
      clamp_sat_s = 1'b0;
    end

    // Output registers load only when the comb pipeline delivers a sample
    if (stg_q[2]) begin
      pcm_d   = clamp_s ^ PCM_FLIP;
      sat_d   = clamp_sat_s;
      valid_d = 1'b1;
    end else begin
      pcm_d   = pcm_q;
      sat_d   = sat_q;
      valid_d = 1'b0;
    end
  end

  // State registers; reset drops any sample in flight
  always_ff @(posedge clk_dac or posedge rst) begin
    if (rst) begin
      sync_q  <= 2'b00;
      i1_q    <= {W{1'b0}};
      i2_q    <= {W{1'b0}};
      i3_q    <= {W{1'b0}};
      cnt_q   <= {DLOG2{1'b0}};
      c1_q    <= {W{1'b0}};
      c2_q    <= {W{1'b0}};
      c3_q    <= {W{1'b0}};
      z1_q    <= {W{1'b0}};
      z2_q    <= {W{1'b0}};
      z3_q    <= {W{1'b0}};
      stg_q   <= 3'b000;
      pcm_q   <= PCM_RST;
      valid_q <= 1'b0;
      sat_q   <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      i1_q    <= i1_d;
      i2_q    <= i2_d;
      i3_q    <= i3_d;
      cnt_q   <= cnt_d;
      c1_q    <= c1_d;
      c2_q    <= c2_d;
      c3_q    <= c3_d;
      z1_q    <= z1_d;
      z2_q    <= z2_d;
      z3_q    <= z3_d;
      stg_q   <= stg_d;
      pcm_q   <= pcm_d;
      valid_q <= valid_d;
      sat_q   <= sat_d;
    end
  end

  assign pcm       = pcm_q;
  assign pcm_valid = valid_q;
  assign sat       = sat_q;

endmodule

// File: tb/tb_jtframe_pdm2pcm.sv
// Scoreboard bench for jtframe_pdm2pcm: instance A (DLOG2=6, signed) sees directed
// bit patterns; instance B (DLOG2=8, offset binary) is fed by a 1st-order DAC model at 16'h4000.
module tb_jtframe_pdm2pcm;

  logic        clk_dac = 1'b0;
  logic        rst     = 1'b1;
  logic        cen     = 1'b0;
  logic        pdm_a   = 1'b0;
  logic        pdm_b   = 1'b0;
  logic [15:0] pcm_a, pcm_b;
  logic        valid_a, valid_b, sat_a, sat_b;

  jtframe_pdm2pcm #(.DLOG2(6), .SIGNED_SND(1'b1)) u_dut_a (
    .clk_dac(clk_dac), .rst(rst), .cen(cen), .pdm_in(pdm_a),
    .pcm(pcm_a), .pcm_valid(valid_a), .sat(sat_a)
  );

  jtframe_pdm2pcm #(.DLOG2(8), .SIGNED_SND(1'b0)) u_dut_b (
    .clk_dac(clk_dac), .rst(rst), .cen(cen), .pdm_in(pdm_b),
    .pcm(pcm_b), .pcm_valid(valid_b), .sat(sat_b)
  );

  always #5 clk_dac = ~clk_dac;

  int cyc = 0;
  always @(posedge clk_dac) cyc <= cyc + 1;

  typedef struct {
    bit          chk;
    logic [15:0] pcm;
    bit          sat;
    int          cyc;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb, en;

  int          total = 0;
  int          bad   = 0;
  int          ncen  = 0;
  int          mode  = 0;   // 0: all ones, 1: all zeros, 2: alternating
  bit          suppress = 1'b0;
  logic [15:0] dac_acc = 16'h0000;
  logic [15:0] exp_pcm = 16'h7FFF;
  bit          exp_sat = 1'b1;
  logic        carry;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, req, cyc);
    end
  endtask

  // One input sample: cen high for one cycle every 4 cycles; expected outputs queued on ticks
  task automatic cen_pulse();
    repeat (2) @(posedge clk_dac);
    @(posedge clk_dac); #1;
    cen = 1'b1;
    ncen++;
    if (!suppress) begin
      if (ncen % 64 == 0) begin
        en.chk = (ncen / 64) >= 4; en.pcm = exp_pcm; en.sat = exp_sat; en.cyc = cyc + 4;
        qa.push_back(en);
      end
      if (ncen % 256 == 0) begin
        en.chk = (ncen / 256) >= 4; en.pcm = 16'h4000; en.sat = 1'b0; en.cyc = cyc + 4;
        qb.push_back(en);
      end
    end
    @(posedge clk_dac); #1;
    cen = 1'b0;
    if (mode == 2) pdm_a = ~pdm_a;
    else           pdm_a = (mode == 0);
    {carry, dac_acc} = {1'b0, dac_acc} + 17'h04000;
    pdm_b = carry;
  endtask

  task automatic do_reset(input int m);
    @(posedge clk_dac); #1;
    rst      = 1'b1;
    mode     = m;
    ncen     = 0;
    suppress = 1'b0;
    dac_acc  = 16'h0000;
    pdm_b    = 1'b0;
    pdm_a    = (m != 1);
    case (m)
      0:       begin exp_pcm = 16'h7FFF; exp_sat = 1'b1; end
      1:       begin exp_pcm = 16'h8000; exp_sat = 1'b0; end
      default: begin exp_pcm = 16'h0000; exp_sat = 1'b0; end
    endcase
    repeat (3) @(posedge clk_dac); #1;
    rst = 1'b0;
  endtask

  // Monitor A: every valid must match the head of the queue in timing and value
  always @(negedge clk_dac) begin
    if (valid_a === 1'b1) begin
      if (qa.size() == 0) begin
        total++; bad++;
        $display("FAIL a_unexpected_valid: got valid at cyc %0d expected none", cyc);
      end else begin
        ea = qa.pop_front();
        chk("a_latency", cyc, ea.cyc);
        if (ea.chk) begin
          chk("a_pcm", {16'h0000, pcm_a}, {16'h0000, ea.pcm});
          chk("a_sat", {31'd0, sat_a}, {31'd0, ea.sat});
        end
      end
    end
  end

  // Monitor B: loopback level within +/-2 LSB once settled
  always @(negedge clk_dac) begin
    if (valid_b === 1'b1) begin
      if (qb.size() == 0) begin
        total++; bad++;
        $display("FAIL b_unexpected_valid: got valid at cyc %0d expected none", cyc);
      end else begin
        eb = qb.pop_front();
        chk("b_latency", cyc, eb.cyc);
        if (eb.chk) begin
          total++;
          if ((int'(pcm_b) - int'(eb.pcm) > 2) || (int'(pcm_b) - int'(eb.pcm) < -2)) begin
            bad++;
            $display("FAIL b_loopback: got %0h expected %0h +/-2", pcm_b, eb.pcm);
          end
          chk("b_sat", {31'd0, sat_b}, 32'd0);
        end
      end
    end
  end

  initial begin
    repeat (2) @(posedge clk_dac);
    @(negedge clk_dac);
    chk("rst_pcm_a",   {16'h0000, pcm_a}, 32'h0000_0000);
    chk("rst_valid_a", {31'd0, valid_a}, 32'd0);
    chk("rst_sat_a",   {31'd0, sat_a},   32'd0);
    chk("rst_pcm_b",   {16'h0000, pcm_b}, 32'h0000_8000);

    // All ones, then all zeros
    do_reset(0);
    repeat (6*64 + 2) cen_pulse();
    chk("drain_ones", qa.size(), 32'd0);
    do_reset(1);
    repeat (6*64 + 2) cen_pulse();
    chk("drain_zeros", qa.size(), 32'd0);

    // Alternating bits on A, DAC loopback on B
    do_reset(2);
    repeat (6*256 + 2) cen_pulse();
    chk("drain_alt_a", qa.size(), 32'd0);
    chk("drain_loop_b", qb.size(), 32'd0);

    // Reset two cycles after a tick: sample must be dropped
    do_reset(0);
    repeat (6*64 - 1) cen_pulse();
    suppress = 1'b1;
    cen_pulse();
    @(posedge clk_dac); #1;
    rst = 1'b1;
    @(negedge clk_dac);
    chk("midrst_pcm",   {16'h0000, pcm_a}, 32'h0000_0000);
    chk("midrst_sat",   {31'd0, sat_a},   32'd0);
    chk("midrst_valid", {31'd0, valid_a}, 32'd0);
    repeat (6) @(posedge clk_dac); #1;
    ncen     = 0;
    suppress = 1'b0;
    dac_acc  = 16'h0000;
    rst      = 1'b0;
    repeat (64 + 2) cen_pulse();
    chk("drain_midrst", qa.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
